regfile_wr_sched: RTL and testbench
===================================

REGFILE_WR_SCHED -- requirements
Module: regfile_wr_sched

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width of the register file write port.
REQ-002 SHALL have parameter CLR_FIRST, default 1: first register index written by the clear sequence (x0 is never written).
REQ-003 SHALL have port i_clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_clear_req, input, 1: one-cycle pulse requesting zeroing of x1..x31.
REQ-006 SHALL have port o_clear_busy, output, 1: high while the clear sequence runs.
REQ-007 SHALL have ports i_req0_valid / i_req1_valid, input, 1 each: writeback request from requester 0 (ALU) / requester 1 (LSU).
REQ-008 SHALL have ports i_req0_addr / i_req1_addr, input, 5 each: destination register.
REQ-009 SHALL have ports i_req0_data / i_req1_data, input, XLEN each: write data.
REQ-010 SHALL have ports o_req0_ready / o_req1_ready, output, 1 each: request accepted this cycle when valid && ready.
REQ-011 SHALL have ports o_wren (1), o_rd_addr (5), o_rd_data (XLEN), output: registered write port driving the register file.

Function
REQ-012 SHALL implement FSM states IDLE and CLEAR; IDLE -> CLEAR on i_clear_req in IDLE; CLEAR -> IDLE after the write to x31.
REQ-013 SHALL, in IDLE with i_clear_req low, grant at most one requester per cycle; the granted requester's ready is high, the other's is low.
REQ-014 SHALL drive both readies low in CLEAR and in the IDLE cycle where i_clear_req is high (clear wins over requesters).
REQ-015 SHALL present an accepted request on o_wren/o_rd_addr/o_rd_data exactly one cycle after acceptance (latency 1, throughput 1/cycle).
REQ-016 SHALL accept requests with addr 0 (ready high) but SHALL keep o_wren low for them.
REQ-017 SHALL, in CLEAR, write 0 to consecutive addresses CLR_FIRST..31, one per cycle, o_wren high on each (31 write cycles for default).
REQ-018 SHALL keep o_clear_busy high from the cycle after i_clear_req through the last clear write cycle, inclusive.
REQ-019 SHALL ignore i_clear_req while in CLEAR (no restart, no extension).
REQ-020 SHALL still emit a request accepted in the cycle before i_clear_req; the clear write stream follows it without gap or overlap.
REQ-021 SHALL hold o_wren low when no write is scheduled; o_rd_addr/o_rd_data are don't-care then but SHALL be stable (hold last value).

Reset
REQ-022 SHALL on rst_n low immediately force: state IDLE, o_wren 0, o_rd_addr 0, o_rd_data 0, o_clear_busy 0, clear counter CLR_FIRST, round-robin pointer favouring requester 0.
REQ-023 SHALL abandon a clear sequence on reset mid-operation; no write is emitted until a new request after rst_n rises.
REQ-024 SHALL drive readies low while rst_n is low.

Configuration
REQ-025 SHALL, with REGFILE_WR_SCHED_RR_EN defined, arbitrate round-robin: on contention the requester not granted last time wins; pointer updates only on a contended grant.
REQ-026 SHALL, without REGFILE_WR_SCHED_RR_EN, use fixed priority: requester 1 (LSU) always wins on contention.

Structure
REQ-027 SHALL take REG_ADDR_W (5), NUM_REGS (32) and the FSM state enum from shared package regfile_pkg.
REQ-028 SHALL place arbitration in sub-module regfile_wr_arb2 (2-way arbiter, round-robin/fixed per macro); FSM, counter and output register stay in the top.

Verification
REQ-029 SHALL cover: req0 valid addr 5 data 0xDEADBEEF alone -> ready0 high, next cycle o_wren=1 addr 5 data 0xDEADBEEF.
REQ-030 SHALL cover: req0 (addr 3) and req1 (addr 4) valid every cycle for 4 cycles, RR_EN defined -> grants 0,1,0,1 and writes 3,4,3,4; without RR_EN -> four writes to addr 4.
REQ-031 SHALL cover: req1 valid addr 0 data 0x1234 -> ready1 high, o_wren stays 0.
REQ-032 SHALL cover: i_clear_req pulse -> o_clear_busy high 31 cycles, o_wren=1 with addr 1..31 data 0, readies low throughout, then IDLE.
REQ-033 SHALL cover: req0 accepted cycle N, i_clear_req cycle N+1 with req1 valid -> req0 write at N+1, ready1 low, clear writes start N+2.
REQ-034 SHALL cover: rst_n asserted during clear at address 10 -> o_wren 0 immediately, o_clear_busy 0, no further writes after release until a new request.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write scheduler.
// Holds the register address width, the register count and the scheduler FSM states.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic {
        StIdle  = 1'b0,
        StClear = 1'b1
    } wr_state_e;

    // x0 is hardwired to zero, so writes to it are accepted but never emitted.
    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/regfile_wr_arb2.sv
// Two-way writeback arbiter used by regfile_wr_sched.
// Macro REGFILE_WR_SCHED_RR_EN: when defined, round-robin on contention (pointer moves only
// on a contended grant). When undefined, fixed priority with requester 1 winning contention.
module regfile_wr_arb2 (
`ifdef REGFILE_WR_SCHED_RR_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

`ifdef REGFILE_WR_SCHED_RR_EN
    // High when requester 1 is owed the next contended grant.
    logic prio1_q;

    // Grant decode: uncontended requests pass through, contention follows the pointer.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && req1) begin
                gnt0 = ~prio1_q;
                gnt1 = prio1_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // Pointer flips to the loser after each contended grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio1_q <= 1'b0;
        end else if (en && req0 && req1) begin
            prio1_q <= ~prio1_q;
        end
    end
`else
    // Fixed priority: the LSU (requester 1) always wins contention.
    always_comb begin
        gnt1 = en & req1;
        gnt0 = en & req0 & ~req1;
    end
`endif

endmodule

// File: rtl/regfile_wr_sched.sv
// Register-file write scheduler: arbitrates ALU/LSU writebacks onto one registered write
// port and runs a clear sequence that zeroes CLR_FIRST..x31, one register per cycle.
// Macro REGFILE_WR_SCHED_RR_EN selects round-robin arbitration (default: fixed, LSU wins).
module regfile_wr_sched
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned CLR_FIRST = 1
) (
    input  logic                  i_clk,
    input  logic                  rst_n,
    input  logic                  i_clear_req,
    output logic                  o_clear_busy,
    input  logic                  i_req0_valid,
    input  logic [REG_ADDR_W-1:0] i_req0_addr,
    input  logic [XLEN-1:0]       i_req0_data,
    output logic                  o_req0_ready,
    input  logic                  i_req1_valid,
    input  logic [REG_ADDR_W-1:0] i_req1_addr,
    input  logic [XLEN-1:0]       i_req1_data,
    output logic                  o_req1_ready,
    output logic                  o_wren,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic [XLEN-1:0]       o_rd_data
);

    localparam logic [REG_ADDR_W-1:0] FirstAddr = REG_ADDR_W'(CLR_FIRST);
    localparam logic [REG_ADDR_W-1:0] LastAddr  = REG_ADDR_W'(NUM_REGS - 1);

    wr_state_e             state_q, state_d;
    logic [REG_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic                  wren_q, wren_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       data_q, data_d;

    logic arb_en;
    logic gnt0;
    logic gnt1;

    // Requesters are only served in IDLE, and a clear request pre-empts them.
    assign arb_en = (state_q == StIdle) && !i_clear_req;

    regfile_wr_arb2 u_arb (
`ifdef REGFILE_WR_SCHED_RR_EN
        .clk   (i_clk),
        .rst_n (rst_n),
`endif
        .en    (arb_en),
        .req0  (i_req0_valid),
        .req1  (i_req1_valid),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    // Readies are forced low asynchronously while reset is held.
    assign o_req0_ready = gnt0 & rst_n;
    assign o_req1_ready = gnt1 & rst_n;

    assign o_clear_busy = (state_q == StClear);
    assign o_wren       = wren_q;
    assign o_rd_addr    = addr_q;
    assign o_rd_data    = data_q;

    // Next-state: FSM, clear counter and the write to present next cycle.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wren_d    = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        unique case (state_q)
            StIdle: begin
                if (i_clear_req) begin
                    // First clear write lands directly after any write already in flight.
                    state_d   = StClear;
                    clr_cnt_d = FirstAddr;
                    wren_d    = 1'b1;
                    addr_d    = FirstAddr;
                    data_d    = '0;
                end else if (gnt0) begin
                    if (!is_zero_reg(i_req0_addr)) begin
                        wren_d = 1'b1;
                        addr_d = i_req0_addr;
                        data_d = i_req0_data;
                    end
                end else if (gnt1) begin
                    if (!is_zero_reg(i_req1_addr)) begin
                        wren_d = 1'b1;
                        addr_d = i_req1_addr;
                        data_d = i_req1_data;
                    end
                end
            end
            StClear: begin
                // clr_cnt_q tracks the address currently on the write port.
                if (clr_cnt_q == LastAddr) begin
                    state_d   = StIdle;
                    clr_cnt_d = FirstAddr;
                end else begin
                    clr_cnt_d = clr_cnt_q + REG_ADDR_W'(1);
                    wren_d    = 1'b1;
                    addr_d    = clr_cnt_q + REG_ADDR_W'(1);
                    data_d    = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered write port.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            clr_cnt_q <= FirstAddr;
            wren_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wren_q    <= wren_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Self-checking bench for regfile_wr_sched: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the expected write stream.
module tb_regfile_wr_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_req = 1'b0;
    logic        v0 = 1'b0;
    logic        v1 = 1'b0;
    logic [4:0]  a0 = '0;
    logic [4:0]  a1 = '0;
    logic [31:0] d0 = '0;
    logic [31:0] d1 = '0;
    logic        ready0, ready1, busy, wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    always #5 clk = ~clk;

    regfile_wr_sched #(
        .XLEN      (32),
        .CLR_FIRST (1)
    ) dut (
        .i_clk        (clk),
        .rst_n        (rst_n),
        .i_clear_req  (clear_req),
        .o_clear_busy (busy),
        .i_req0_valid (v0),
        .i_req0_addr  (a0),
        .i_req0_data  (d0),
        .o_req0_ready (ready0),
        .i_req1_valid (v1),
        .i_req1_addr  (a1),
        .i_req1_data  (d1),
        .o_req1_ready (ready1),
        .o_wren       (wren),
        .o_rd_addr    (rd_addr),
        .o_rd_data    (rd_data)
    );

    // One scheduled write-port cycle; clr marks cycles belonging to the clear sequence.
    typedef struct {
        bit          wren;
        bit          clr;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t  q[$];
    wr_t  cur;
    int   favour;
    int   errors;
    int   checks;
    int   busy_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cur    = '{1'b0, 1'b0, 5'd0, 32'd0};
        favour = 0;
    endtask

    // Entered at posedge+1 with inputs set; leaves at the next posedge+1.
    task automatic step();
        bit e0, e1;
        wr_t w;
        @(negedge clk);
        e0 = 1'b0;
        e1 = 1'b0;
        if (rst_n && !cur.clr && !clear_req) begin
            if (v0 && v1) begin
`ifdef REGFILE_WR_SCHED_RR_EN
                if (favour == 0) begin
                    e0 = 1'b1;
                    favour = 1;
                end else begin
                    e1 = 1'b1;
                    favour = 0;
                end
`else
                e1 = 1'b1;
`endif
            end else begin
                e0 = v0;
                e1 = v1;
            end
        end
        check_eq("ready0", ready0, e0);
        check_eq("ready1", ready1, e1);
        check_eq("wren", wren, cur.wren);
        check_eq("busy", busy, cur.clr);
        check_eq("rd_addr", rd_addr, cur.addr);
        check_eq("rd_data", rd_data, cur.data);
        if (busy) busy_cnt++;
        if (rst_n) begin
            if (!cur.clr && clear_req) begin
                for (int a = 1; a < 32; a++) q.push_back('{1'b1, 1'b1, 5'(a), 32'd0});
            end else if (e0) begin
                q.push_back('{a0 != 5'd0, 1'b0, a0, d0});
            end else if (e1) begin
                q.push_back('{a1 != 5'd0, 1'b0, a1, d1});
            end
        end
        @(posedge clk);
        if (q.size() > 0) begin
            w = q.pop_front();
            if (w.wren) begin
                cur = w;
            end else begin
                cur.wren = 1'b0;
                cur.clr  = 1'b0;
            end
        end else begin
            cur.wren = 1'b0;
            cur.clr  = 1'b0;
        end
        #1;
    endtask

    // Asserts reset away from the clock edge and checks outputs drop immediately.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_wren", wren, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_addr", rd_addr, 5'd0);
        check_eq("rst_data", rd_data, 32'd0);
        check_eq("rst_ready0", ready0, 1'b0);
        check_eq("rst_ready1", ready1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        v0 = 1'b0;
        v1 = 1'b0;
        clear_req = 1'b0;
    endtask

    initial begin
        int guard;
        errors   = 0;
        checks   = 0;
        busy_cnt = 0;
        model_reset();

        // Requests held valid across reset must not see ready.
        v0 = 1'b1;
        v1 = 1'b1;
        apply_reset();
        idle_inputs();
        step();

        // Single ALU write.
        v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEADBEEF;
        step();
        idle_inputs();
        repeat (2) step();

        // Sustained contention.
        v0 = 1'b1; a0 = 5'd3; d0 = 32'h0000_0003;
        v1 = 1'b1; a1 = 5'd4; d1 = 32'h0000_0004;
        repeat (4) step();
        idle_inputs();
        repeat (2) step();

        // Write to x0 is accepted but not emitted.
        v1 = 1'b1; a1 = 5'd0; d1 = 32'h0000_1234;
        step();
        idle_inputs();
        repeat (2) step();

        // Full clear with a request pending and a second clear pulse mid-sequence.
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        busy_cnt = 0;
        v0 = 1'b1; a0 = 5'd7; d0 = 32'hA5A5_0007;
        for (int i = 0; i < 34; i++) begin
            clear_req = (i == 10);
            step();
            if (i == 31) v0 = 1'b0;
        end
        check_eq("busy_len", busy_cnt, 31);
        idle_inputs();
        step();

        // Request accepted the cycle before clear; clear wins over a concurrent LSU request.
        v0 = 1'b1; a0 = 5'd9; d0 = 32'h1111_2222;
        step();
        v0 = 1'b0;
        v1 = 1'b1; a1 = 5'd12; d1 = 32'h3333_4444;
        clear_req = 1'b1;
        step();
        idle_inputs();
        repeat (33) step();

        // Reset in the middle of a clear sequence, at address 10.
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        guard = 0;
        while (!(cur.clr && cur.addr == 5'd10) && guard < 40) begin
            step();
            guard++;
        end
        check_eq("reach_clr10", guard < 40, 1'b1);
        v0 = 1'b1; a0 = 5'd2; d0 = 32'h0BAD_F00D;
        apply_reset();
        v0 = 1'b0;
        repeat (3) step();
        v0 = 1'b1; a0 = 5'd2; d0 = 32'h600D_F00D;
        step();
        idle_inputs();
        repeat (2) step();

        // Random traffic, occasional clear pulses.
        for (int i = 0; i < 500; i++) begin
            v0 = $urandom_range(0, 1);
            v1 = $urandom_range(0, 1);
            a0 = 5'($urandom_range(0, 31));
            a1 = 5'($urandom_range(0, 31));
            d0 = $urandom;
            d1 = $urandom;
            clear_req = ($urandom_range(0, 39) == 0);
            step();
        end
        idle_inputs();
        repeat (35) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
